load_store_unit: RTL and testbench
==================================

# load_store_unit

Data-side load/store unit placed between the core's execute stage and the dual-port data memory / MMIO bus. It accepts one RV32I load or store request at a time, checks alignment, and drives the word-wide memory data port. Byte and halfword stores are done as read-modify-write sequences. Loaded data is extracted and sign- or zero-extended before it is returned to the core.

## Interface
- No parameters. Address and data widths are fixed at 32 bits, because the memory port is word-only.
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  core presents a request
- req_ready  out  1  high only in IDLE; a request is accepted on a rising edge with req_valid && req_ready
- req_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010)
- req_address  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  response held until accepted
- resp_ready  in  1  core accepts the response
- resp_rdata  out  32  extended load data; 0 for stores and faults
- resp_fault  out  2  00 ok, 01 misaligned, 10 access fault (no device selected), 11 illegal funct3
- mem_address  out  32  bus address, word-aligned (bits [1:0] = 0); 0 when idle
- mem_read_data  in  32  asynchronous read data from the bus
- mem_write_data  out  32  full word to write
- mem_write_data_sig  out  1  write strobe, 1 = write on this edge
- mem_selected  in  1  OR of device select outputs for mem_address

## Operation
- States: IDLE, ACCESS, WRITE, RESP.
- On accept, latch address, funct3, store flag and wdata. Then classify the request:
  - illegal funct3 (011, 110, 111, or stores with 1xx) -> RESP, fault 11
  - misaligned (H: addr[0] != 0; W: addr[1:0] != 0) -> RESP, fault 01
  - otherwise -> ACCESS
- Misaligned and illegal requests produce no bus activity.
- ACCESS: mem_address = {addr[31:2], 2'b00}.
  - If mem_selected = 0: -> RESP, fault 10. No write is issued.
  - Load: capture the extracted word -> RESP.
    - LB/LBU use byte addr[1:0]; LH/LHU use half addr[1].
    - LB/LH sign-extend; LBU/LHU zero-extend.
  - SW: mem_write_data = wdata, mem_write_data_sig = 1 this cycle -> RESP.
  - SB/SH: capture mem_read_data into a merge register, then insert the byte/half at the addressed lane -> WRITE.
- WRITE: mem_address held, mem_write_data = merged word, mem_write_data_sig = 1 for exactly one cycle -> RESP.
- RESP: resp_valid = 1; outputs are stable until resp_valid && resp_ready; -> IDLE on that edge.
- mem_write_data_sig is never high outside ACCESS (SW) and WRITE.

## Timing
- Request accepted at edge N. resp_valid rises after:
  - edge N+1 for fault 01/11
  - edge N+2 for loads, SW, and fault 10
  - edge N+3 for SB/SH
- Back-to-back throughput: the earliest next accept is the edge after the response handshake.
- A response handshake is followed by at least one IDLE cycle with req_ready = 1.
- Reset (asserted at any time, including mid-RMW) forces IDLE immediately, with no clock needed. Outputs then read:
  - req_ready = 1
  - resp_valid = 0, resp_rdata = 0, resp_fault = 00
  - mem_address = 0, mem_write_data = 0, mem_write_data_sig = 0
- An RMW interrupted by reset leaves memory unmodified.

## Structure
- Shared package riscv_lsu_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - fault codes (FAULT_NONE, FAULT_MISALIGN, FAULT_ACCESS, FAULT_ILLEGAL)
  - the 2-bit state encoding
- One combinational sub-module, lsu_align, provides the load-extract function (word, addr[1:0], funct3 -> 32-bit result) and the store-merge function (old word, wdata, addr[1:0], funct3 -> new word).
- The FSM and registers stay in load_store_unit.

## Test plan
- LW at 0x80000010, bus returns 0xDEADBEEF, selected = 1 -> resp at N+2: rdata 0xDEADBEEF, fault 00, no write strobe.
- LB at 0x80000013 with word 0x80FF_1234 -> rdata 0xFFFFFF80. LBU at the same address -> 0x00000080. LHU at 0x80000012 -> 0x000080FF.
- SB 0x000000AA at 0x80000021, old word 0x11223344:
  - one write strobe in WRITE with data 0x1122AA44
  - resp at N+3, fault 00
- LH at 0x80000001 -> resp at N+1, fault 01, no strobe, mem_address stays 0. SW at 0x00000400 with mem_selected = 0 -> fault 10, no strobe.
- Hold resp_ready = 0 for 5 cycles: resp held, req_ready = 0, second req_valid ignored. Release: next request accepted one cycle later.
- Assert rst_n = 0 during SH in WRITE-pending ACCESS: strobe never asserted, all outputs at reset values immediately, next request behaves normally.

Source files
------------

// File: rtl/riscv_lsu_pkg.sv
// Shared definitions for the data-side load/store unit: funct3 encodings,
// response fault codes, FSM state encoding and request classification helpers.
package riscv_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_ACCESS   = 2'b10;
  localparam logic [1:0] FAULT_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_WRITE  = 2'b10,
    ST_RESP   = 2'b11
  } lsu_state_t;

  // Unsigned variants exist only for loads; 011/110/111 are never legal.
  function automatic logic is_illegal(input logic store, input logic [2:0] funct3);
    logic bad;
    case (funct3)
      F3_B, F3_H, F3_W: bad = 1'b0;
      F3_BU, F3_HU:     bad = store;
      default:          bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Only meaningful for legal funct3; the low two bits give the access size.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic mis;
    case (funct3[1:0])
      2'b01:   mis = addr_lo[0];
      2'b10:   mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core request/response handshake plus the word-wide data memory port.
// slave: the load/store unit; master: the core and bus it talks to.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_address;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_fault;
  logic [31:0] mem_address;
  logic [31:0] mem_read_data;
  logic [31:0] mem_write_data;
  logic        mem_write_data_sig;
  logic        mem_selected;

  modport slave (
    input  req_valid, req_store, req_funct3, req_address, req_wdata,
    input  resp_ready, mem_read_data, mem_selected,
    output req_ready, resp_valid, resp_rdata, resp_fault,
    output mem_address, mem_write_data, mem_write_data_sig
  );

  modport master (
    output req_valid, req_store, req_funct3, req_address, req_wdata,
    output resp_ready, mem_read_data, mem_selected,
    input  req_ready, resp_valid, resp_rdata, resp_fault,
    input  mem_address, mem_write_data, mem_write_data_sig
  );
endinterface

// File: rtl/lsu_align.sv
// Lane handling for the word-only memory port: extracts and extends load
// data, and merges byte/halfword store data into an existing word.
module lsu_align
  import riscv_lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [31:0] shifted_s;
  logic [15:0] half_s;

  // Load extract: pick the addressed lane, then sign- or zero-extend.
  always_comb begin
    shifted_s = word >> {addr_lo, 3'b000};
    half_s    = addr_lo[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    load_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
      F3_H:    load_data = {{16{half_s[15]}}, half_s};
      F3_W:    load_data = word;
      F3_BU:   load_data = {24'h000000, shifted_s[7:0]};
      F3_HU:   load_data = {16'h0000, half_s};
      default: load_data = 32'h0000_0000;
    endcase
  end

  // Store merge: overwrite only the addressed lane of the old word.
  always_comb begin
    merged = word;
    case (funct3)
      F3_B: begin
        case (addr_lo)
          2'd0:    merged[7:0]   = wdata[7:0];
          2'd1:    merged[15:8]  = wdata[7:0];
          2'd2:    merged[23:16] = wdata[7:0];
          2'd3:    merged[31:24] = wdata[7:0];
          default: merged        = word;
        endcase
      end
      F3_H: begin
        if (addr_lo[1]) begin
          merged[31:16] = wdata[15:0];
        end else begin
          merged[15:0] = wdata[15:0];
        end
      end
      F3_W:    merged = wdata;
      default: merged = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I data-side load/store unit. One request in flight; a classify cycle
// follows each accept, sub-word stores are read-modify-write on the word port.
module load_store_unit
  import riscv_lsu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  load_store_unit_if.slave bus
);

  lsu_state_t  state_r, state_s;
  logic        pending_r, pending_s;   // request latched, not yet classified
  logic        store_r, store_s;
  logic [2:0]  funct3_r, funct3_s;
  logic [31:0] addr_r, addr_s;
  logic [31:0] wdata_r, wdata_s;
  logic [31:0] merge_r, merge_s;
  logic [31:0] rdata_r, rdata_s;
  logic [1:0]  fault_r, fault_s;
  logic [31:0] load_data_s;
  logic [31:0] merged_s;

  lsu_align u_align (
    .word      (bus.mem_read_data),
    .addr_lo   (addr_r[1:0]),
    .funct3    (funct3_r),
    .wdata     (wdata_r),
    .load_data (load_data_s),
    .merged    (merged_s)
  );

  // State and request registers; reset returns to IDLE without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      pending_r <= 1'b0;
      store_r   <= 1'b0;
      funct3_r  <= 3'b000;
      addr_r    <= 32'h0000_0000;
      wdata_r   <= 32'h0000_0000;
      merge_r   <= 32'h0000_0000;
      rdata_r   <= 32'h0000_0000;
      fault_r   <= FAULT_NONE;
    end else begin
      state_r   <= state_s;
      pending_r <= pending_s;
      store_r   <= store_s;
      funct3_r  <= funct3_s;
      addr_r    <= addr_s;
      wdata_r   <= wdata_s;
      merge_r   <= merge_s;
      rdata_r   <= rdata_s;
      fault_r   <= fault_s;
    end
  end

  // Next-state logic: accept, classify, bus access, RMW write, response.
  always_comb begin
    state_s   = state_r;
    pending_s = pending_r;
    store_s   = store_r;
    funct3_s  = funct3_r;
    addr_s    = addr_r;
    wdata_s   = wdata_r;
    merge_s   = merge_r;
    rdata_s   = rdata_r;
    fault_s   = fault_r;
    case (state_r)
      ST_IDLE: begin
        if (pending_r) begin
          pending_s = 1'b0;
          if (is_illegal(store_r, funct3_r)) begin
            fault_s = FAULT_ILLEGAL;
            state_s = ST_RESP;
          end else if (is_misaligned(funct3_r, addr_r[1:0])) begin
            fault_s = FAULT_MISALIGN;
            state_s = ST_RESP;
          end else begin
            state_s = ST_ACCESS;
          end
        end else if (bus.req_valid) begin
          pending_s = 1'b1;
          store_s   = bus.req_store;
          funct3_s  = bus.req_funct3;
          addr_s    = bus.req_address;
          wdata_s   = bus.req_wdata;
          rdata_s   = 32'h0000_0000;
          fault_s   = FAULT_NONE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (!bus.mem_selected) begin
          fault_s = FAULT_ACCESS;
          state_s = ST_RESP;
        end else if (!store_r) begin
          rdata_s = load_data_s;
          state_s = ST_RESP;
        end else if (funct3_r == F3_W) begin
          state_s = ST_RESP;
        end else begin
          merge_s = merged_s;
          state_s = ST_WRITE;
        end
      end
      ST_WRITE: state_s = ST_RESP;
      ST_RESP: begin
        if (bus.resp_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Output decode from registered state; bus strobe only in SW ACCESS or WRITE.
  always_comb begin
    bus.req_ready          = (state_r == ST_IDLE) && !pending_r;
    bus.resp_valid         = (state_r == ST_RESP);
    bus.resp_rdata         = 32'h0000_0000;
    bus.resp_fault         = FAULT_NONE;
    bus.mem_address        = 32'h0000_0000;
    bus.mem_write_data     = 32'h0000_0000;
    bus.mem_write_data_sig = 1'b0;
    case (state_r)
      ST_ACCESS: begin
        bus.mem_address = {addr_r[31:2], 2'b00};
        if (store_r && (funct3_r == F3_W) && bus.mem_selected) begin
          bus.mem_write_data     = wdata_r;
          bus.mem_write_data_sig = 1'b1;
        end else begin
          bus.mem_write_data_sig = 1'b0;
        end
      end
      ST_WRITE: begin
        bus.mem_address        = {addr_r[31:2], 2'b00};
        bus.mem_write_data     = merge_r;
        bus.mem_write_data_sig = 1'b1;
      end
      ST_RESP: begin
        bus.resp_rdata = rdata_r;
        bus.resp_fault = fault_r;
      end
      default: bus.mem_address = 32'h0000_0000;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word memory model behind the
// bus port and a response scoreboard (rdata, fault, accept-to-response latency).
module tb_load_store_unit;
  import riscv_lsu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  load_store_unit_if bus();

  load_store_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  fault;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem [0:63];
  int          checks = 0;
  int          errors = 0;
  int          strobes = 0;
  int          bus_cycles = 0;
  logic [31:0] last_wdata = 32'h0;
  logic [31:0] last_waddr = 32'h0;
  logic        pre_en = 1'b0;
  logic [5:0]  pre_idx = 6'd0;
  logic [31:0] pre_val = 32'h0;

  // Devices decode the upper half of the address space; read data is asynchronous.
  always_comb begin
    bus.mem_selected  = bus.mem_address[31];
    bus.mem_read_data = mem[bus.mem_address[7:2]];
  end

  // Memory writes, preloads and bus activity counters.
  always @(posedge clk) begin
    if (pre_en) begin
      mem[pre_idx] <= pre_val;
    end else if (bus.mem_write_data_sig && bus.mem_selected) begin
      mem[bus.mem_address[7:2]] <= bus.mem_write_data;
    end
    if (bus.mem_write_data_sig) begin
      strobes    <= strobes + 1;
      last_wdata <= bus.mem_write_data;
      last_waddr <= bus.mem_address;
    end
    if (bus.mem_address != 32'h0) bus_cycles <= bus_cycles + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] val);
    @(negedge clk);
    pre_en = 1'b1; pre_idx = idx; pre_val = val;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  // Reference load extraction, written independently of the RTL lane logic.
  function automatic logic [31:0] ref_load(input logic [31:0] w, input int a, input logic [2:0] f3);
    logic [31:0] sh;
    sh = w >> (8 * a);
    case (f3)
      F3_B:    return sh[7]  ? (sh | 32'hFFFF_FF00) : (sh & 32'h0000_00FF);
      F3_H:    return sh[15] ? (sh | 32'hFFFF_0000) : (sh & 32'h0000_FFFF);
      F3_W:    return w;
      F3_BU:   return sh & 32'h0000_00FF;
      F3_HU:   return sh & 32'h0000_FFFF;
      default: return 32'h0;
    endcase
  endfunction

  task automatic drive_req(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_store = st; bus.req_funct3 = f3;
    bus.req_address = a; bus.req_wdata = wd;
  endtask

  // Returns right after the accepting rising edge.
  task automatic accept(input string tag);
    int n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_accept"}, 32'(n < 20), 32'd1);
    @(posedge clk);
  endtask

  // Called right after the accept edge; leaves the bench at a negedge with resp_valid high.
  task automatic wait_resp(input string tag);
    exp_t e;
    int   lat = 0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check({tag, "_early"}, 32'(bus.resp_valid), 32'd0);
    while (lat < 12) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.resp_valid) break;
    end
    check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_lat"}, lat, e.lat);
      check({tag, "_rdata"}, bus.resp_rdata, e.rdata);
      check({tag, "_fault"}, 32'(bus.resp_fault), 32'(e.fault));
    end
  endtask

  task automatic handshake(input string tag);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check({tag, "_resp_drop"}, 32'(bus.resp_valid), 32'd0);
    check({tag, "_idle_ready"}, 32'(bus.req_ready), 32'd1);
  endtask

  task automatic do_op(input string tag, input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic [1:0] exp_f,
                       input int lat, input int exp_str);
    int s0 = strobes;
    int b0 = bus_cycles;
    drive_req(st, f3, a, wd);
    sb.push_back('{rdata: exp_rd, fault: exp_f, lat: lat});
    accept(tag);
    wait_resp(tag);
    handshake(tag);
    check({tag, "_strobes"}, strobes - s0, exp_str);
    if (exp_f == FAULT_MISALIGN || exp_f == FAULT_ILLEGAL) begin
      check({tag, "_no_bus"}, bus_cycles - b0, 32'd0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    check({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
    check({tag, "_resp_rdata"}, bus.resp_rdata, 32'd0);
    check({tag, "_resp_fault"}, 32'(bus.resp_fault), 32'd0);
    check({tag, "_mem_address"}, bus.mem_address, 32'd0);
    check({tag, "_mem_wdata"}, bus.mem_write_data, 32'd0);
    check({tag, "_mem_sig"}, 32'(bus.mem_write_data_sig), 32'd0);
  endtask

  initial begin
    int          s0;
    logic [31:0] old_word;
    logic [31:0] exp_rd;
    logic [1:0]  exp_f;
    int          exp_lat;

    bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_address = 32'h0; bus.req_wdata = 32'h0; bus.resp_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Word load
    preload(6'd4, 32'hDEAD_BEEF);
    do_op("lw", 1'b0, F3_W, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, FAULT_NONE, 2, 0);

    // Sub-word loads with sign/zero extension
    preload(6'd4, 32'h80FF_1234);
    do_op("lb",  1'b0, F3_B,  32'h8000_0013, 32'h0, 32'hFFFF_FF80, FAULT_NONE, 2, 0);
    do_op("lbu", 1'b0, F3_BU, 32'h8000_0013, 32'h0, 32'h0000_0080, FAULT_NONE, 2, 0);
    do_op("lhu", 1'b0, F3_HU, 32'h8000_0012, 32'h0, 32'h0000_80FF, FAULT_NONE, 2, 0);

    // Byte store via read-modify-write
    preload(6'd8, 32'h1122_3344);
    do_op("sb", 1'b1, F3_B, 32'h8000_0021, 32'h0000_00AA, 32'h0, FAULT_NONE, 3, 1);
    check("sb_wdata", last_wdata, 32'h1122_AA44);
    check("sb_waddr", last_waddr, 32'h8000_0020);
    check("sb_mem", mem[8], 32'h1122_AA44);

    // Faults: misaligned, unselected device, illegal funct3
    do_op("lh_mis", 1'b0, F3_H, 32'h8000_0001, 32'h0, 32'h0, FAULT_MISALIGN, 1, 0);
    do_op("lw_mis", 1'b0, F3_W, 32'h8000_0012, 32'h0, 32'h0, FAULT_MISALIGN, 1, 0);
    do_op("sw_unsel", 1'b1, F3_W, 32'h0000_0400, 32'h1234_5678, 32'h0, FAULT_ACCESS, 2, 0);
    do_op("ld_f011", 1'b0, 3'b011, 32'h8000_0010, 32'h0, 32'h0, FAULT_ILLEGAL, 1, 0);
    do_op("st_f100", 1'b1, 3'b100, 32'h8000_0010, 32'h0, 32'h0, FAULT_ILLEGAL, 1, 0);

    // Full-word store, then halfword RMW on top of it
    do_op("sw", 1'b1, F3_W, 32'h8000_0030, 32'hCAFE_F00D, 32'h0, FAULT_NONE, 2, 1);
    check("sw_mem", mem[12], 32'hCAFE_F00D);
    do_op("sh", 1'b1, F3_H, 32'h8000_0032, 32'h0000_1234, 32'h0, FAULT_NONE, 3, 1);
    check("sh_mem", mem[12], 32'h1234_F00D);

    // Every load size at every byte offset
    preload(6'd9, 32'h8A7B_6C5D);
    foreach (sb[i]) check("sb_leftover", 32'd1, 32'd0);
    for (int k = 0; k < 5; k++) begin
      for (int a = 0; a < 4; a++) begin
        logic [2:0] f3;
        f3 = (k < 3) ? 3'(k) : 3'(k + 1);
        if ((f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 0)) begin
          exp_rd = 32'h0; exp_f = FAULT_MISALIGN; exp_lat = 1;
        end else begin
          exp_rd = ref_load(32'h8A7B_6C5D, a, f3); exp_f = FAULT_NONE; exp_lat = 2;
        end
        do_op($sformatf("sweep_f%0d_a%0d", f3, a), 1'b0, f3, 32'h8000_0024 + 32'(a),
              32'h0, exp_rd, exp_f, exp_lat, 0);
      end
    end

    // Back-pressure: response held, second request ignored until handshake
    preload(6'd5, 32'h0BAD_F00D);
    drive_req(1'b0, F3_W, 32'h8000_0014, 32'h0);
    sb.push_back('{rdata: 32'h0BAD_F00D, fault: FAULT_NONE, lat: 2});
    accept("hold_lw");
    wait_resp("hold_lw");
    bus.req_valid = 1'b1; bus.req_store = 1'b0; bus.req_funct3 = F3_BU;
    bus.req_address = 32'h8000_0014;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("hold%0d_valid", i), 32'(bus.resp_valid), 32'd1);
      check($sformatf("hold%0d_ready", i), 32'(bus.req_ready), 32'd0);
      check($sformatf("hold%0d_rdata", i), bus.resp_rdata, 32'h0BAD_F00D);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check("hold_release_valid", 32'(bus.resp_valid), 32'd0);
    check("hold_release_ready", 32'(bus.req_ready), 32'd1);
    sb.push_back('{rdata: 32'h0000_000D, fault: FAULT_NONE, lat: 2});
    @(posedge clk);
    wait_resp("after_hold");
    handshake("after_hold");

    // Reset during the ACCESS cycle of a halfword RMW
    old_word = mem[8];
    s0 = strobes;
    drive_req(1'b1, F3_H, 32'h8000_0022, 32'h0000_BEEF);
    accept("rmw_rst");
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rmw_rst_access_addr", bus.mem_address, 32'h8000_0020);
    check("rmw_rst_access_sig", 32'(bus.mem_write_data_sig), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("rmw_rst");
    @(posedge clk);
    @(negedge clk);
    check("rmw_rst_hold_sig", 32'(bus.mem_write_data_sig), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rmw_rst_strobes", strobes - s0, 32'd0);
    check("rmw_rst_mem", mem[8], old_word);

    // Normal operation after reset
    do_op("post_rst_lh", 1'b0, F3_H, 32'h8000_0020, 32'h0, 32'hFFFF_AA44, FAULT_NONE, 2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "time limit reached");
  end

endmodule
